// File: rtl/dly_train_if.sv
// Signal bundle between the delay-training controller and the lane delay elements / data comparator.
`default_nettype none

interface dly_train_if #(
  parameter int W = 8
);
  logic             start;
  logic             idelayctrl_rdy;
  logic [W-1:0]     ld;
  logic [5*W-1:0]   cntvaluein;
  logic [5*W-1:0]   cntvalueout;
  logic             sample_req;
  logic             sample_ack;
  logic [W-1:0]     pass;
  logic             busy;
  logic             done;
  logic [W-1:0]     fail;
  logic [5*W-1:0]   final_tap;

  modport master (
    input  start, idelayctrl_rdy, cntvalueout, sample_ack, pass,
    output ld, cntvaluein, sample_req, busy, done, fail, final_tap
  );

  modport slave (
    output start, idelayctrl_rdy, cntvalueout, sample_ack, pass,
    input  ld, cntvaluein, sample_req, busy, done, fail, final_tap
  );
endinterface

`default_nettype wire

// File: rtl/dly_train_ctrl.sv
// Per-lane input-delay training: sweeps all taps, finds the widest passing window per lane
// and loads its centre tap.
`default_nettype none

module dly_train_ctrl #(
  parameter int W      = 8,
  parameter int TAPS   = 32,
  parameter int SETTLE = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  dly_train_if.master  bus
);

  localparam logic [3:0] ST_IDLE         = 4'd0;
  localparam logic [3:0] ST_WAIT_RDY     = 4'd1;
  localparam logic [3:0] ST_LOAD         = 4'd2;
  localparam logic [3:0] ST_SETTLE       = 4'd3;
  localparam logic [3:0] ST_SAMPLE       = 4'd4;
  localparam logic [3:0] ST_EVAL         = 4'd5;
  localparam logic [3:0] ST_APPLY        = 4'd6;
  localparam logic [3:0] ST_APPLY_SETTLE = 4'd7;
  localparam logic [3:0] ST_DONE         = 4'd8;

  localparam logic [4:0]  LAST_TAP    = 5'(TAPS - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

  logic [3:0]     state;
  logic [4:0]     t;
  logic [15:0]    cnt;
  logic [W-1:0]   pass_q;
  logic [W-1:0]   fail_q;
  logic [5*W-1:0] final_q;

  logic           busy_w;
  logic           rdy_drop;
  logic           start_go;
  logic           clear_win;
  logic           eval_en;
  logic           settle_last;
  logic           last_tap;
  logic [W-1:0]   mismatch;
  logic [W-1:0]   no_win;
  logic [5*W-1:0] final_bus;

  assign busy_w      = (state != ST_IDLE) && (state != ST_DONE);
  // Losing IDELAYCTRL ready outranks every other event, including a same-cycle sample_ack.
  assign rdy_drop    = busy_w && (state != ST_WAIT_RDY) && !bus.idelayctrl_rdy;
  assign start_go    = bus.start && !busy_w;
  assign clear_win   = start_go || rdy_drop;
  assign eval_en     = (state == ST_EVAL) && !rdy_drop;
  assign settle_last = (state == ST_SETTLE) && (cnt == SETTLE_LAST);
  assign last_tap    = (t == LAST_TAP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      t      <= 5'd0;
      cnt    <= 16'd0;
      pass_q <= '0;
    end else if (rdy_drop) begin
      state <= ST_WAIT_RDY;
      t     <= 5'd0;
      cnt   <= 16'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state <= ST_WAIT_RDY;
            t     <= 5'd0;
          end
        end
        ST_WAIT_RDY: begin
          if (bus.idelayctrl_rdy) state <= ST_LOAD;
        end
        ST_LOAD: begin
          state <= ST_SETTLE;
          cnt   <= 16'd0;
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= ST_SAMPLE;
            cnt   <= 16'd0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_SAMPLE: begin
          if (bus.sample_ack) begin
            pass_q <= bus.pass;
            state  <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (t < LAST_TAP) begin
            t     <= t + 5'd1;
            state <= ST_LOAD;
          end else begin
            state <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          state <= ST_APPLY_SETTLE;
          cnt   <= 16'd0;
        end
        ST_APPLY_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= ST_DONE;
            cnt   <= 16'd0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_lane
    logic       win_open;
    logic [4:0] win_start;
    logic [5:0] win_len;
    logic [4:0] best_start;
    logic [5:0] best_len;
    logic       p;
    logic       close_now;
    logic [4:0] cand_start;
    logic [5:0] cand_len;

    // Candidate is the window as it stands after this tap; it closes on a fail or at the last tap.
    assign p          = pass_q[i];
    assign cand_start = (p && !win_open) ? t : win_start;
    assign cand_len   = p ? (win_open ? win_len + 6'd1 : 6'd1) : win_len;
    assign close_now  = p ? last_tap : win_open;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        win_open   <= 1'b0;
        win_start  <= 5'd0;
        win_len    <= 6'd0;
        best_start <= 5'd0;
        best_len   <= 6'd0;
      end else if (clear_win) begin
        win_open   <= 1'b0;
        win_start  <= 5'd0;
        win_len    <= 6'd0;
        best_start <= 5'd0;
        best_len   <= 6'd0;
      end else if (eval_en) begin
        win_open  <= p && !last_tap;
        win_start <= cand_start;
        win_len   <= p ? cand_len : 6'd0;
        if (close_now && (cand_len > best_len)) begin
          best_start <= cand_start;
          best_len   <= cand_len;
        end
      end
    end

    assign final_bus[5*i +: 5] = best_start + best_len[5:1];
    assign no_win[i]           = (best_len == 6'd0);
    assign mismatch[i]         = (bus.cntvalueout[5*i +: 5] != t);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fail_q  <= '0;
      final_q <= '0;
    end else if (start_go) begin
      fail_q <= '0;
    end else if (!rdy_drop) begin
      if (settle_last) fail_q <= fail_q | mismatch;
      if (state == ST_APPLY) begin
        fail_q  <= fail_q | no_win;
        final_q <= final_bus;
      end
    end
  end

  assign bus.ld         = ((state == ST_LOAD) || (state == ST_APPLY)) ? '1 : '0;
  assign bus.cntvaluein = (state == ST_LOAD)  ? {W{t}} :
                          (state == ST_APPLY) ? final_bus : '0;
  assign bus.sample_req = (state == ST_SAMPLE);
  assign bus.busy       = busy_w;
  assign bus.done       = (state == ST_DONE);
  assign bus.fail       = fail_q;
  assign bus.final_tap  = final_q;

endmodule

`default_nettype wire

// File: tb/tb_dly_train_ctrl.sv
// Self-checking bench for dly_train_ctrl: delay-element and comparator model, vector table, scoreboard.
`default_nettype none

module tb_dly_train_ctrl;
  localparam int W      = 4;
  localparam int TAPS   = 32;
  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  dly_train_if #(.W(W)) bus ();

  dly_train_ctrl #(.W(W), .TAPS(TAPS), .SETTLE(SETTLE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0][31:0] mask;
    logic [W-1:0]       stuck;
    int                 ack_len;
    bit                 noise;
    logic [5*W-1:0]     exp_final;
    logic [W-1:0]       exp_fail;
  } vec_t;

  typedef struct {
    logic [5*W-1:0] final_tap;
    logic [W-1:0]   fail;
  } exp_t;

  vec_t vecs [6];
  exp_t sb [$];

  logic [W-1:0][31:0] mask;
  logic [W-1:0]       stuck;
  int                 ack_len;
  bit                 noise;
  logic [4:0]         tap_reg [W];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ld_cyc [$];
  int req_run = 0;
  int req_max = 0;

  // Delay elements latch on ld; comparator answers after ack_len request cycles.
  initial begin : responder
    int  wait_cnt;
    bit  acked;
    wait_cnt = 0;
    acked = 0;
    bus.sample_ack  = 1'b0;
    bus.pass        = '0;
    bus.cntvalueout = '0;
    for (int i = 0; i < W; i++) tap_reg[i] = 5'd0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < W; i++) begin
        if (bus.ld[i]) tap_reg[i] = bus.cntvaluein[5*i +: 5];
        bus.cntvalueout[5*i +: 5] = stuck[i] ? 5'd0 : tap_reg[i];
      end
      if (bus.sample_req && !acked) begin
        if (wait_cnt + 1 >= ack_len) begin
          bus.sample_ack = 1'b1;
          for (int i = 0; i < W; i++) bus.pass[i] = mask[i][tap_reg[i]];
          acked = 1;
        end else begin
          bus.sample_ack = 1'b0;
          bus.pass = noise ? W'($urandom) : '0;
          wait_cnt++;
        end
      end else if (bus.sample_req) begin
        bus.sample_ack = 1'b0;
      end else begin
        acked = 0;
        wait_cnt = 0;
        if (noise) begin
          bus.sample_ack = 1'($urandom_range(0, 1));
          bus.pass       = W'($urandom);
        end else begin
          bus.sample_ack = 1'b0;
          bus.pass       = '0;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.ld === '1) ld_cyc.push_back(cyc);
      if (bus.sample_req === 1'b1) begin
        req_run++;
        if (req_run > req_max) req_max = req_run;
      end else begin
        req_run = 0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic load_vec(input vec_t v);
    mask    = v.mask;
    stuck   = v.stuck;
    ack_len = v.ack_len;
    noise   = v.noise;
  endtask

  task automatic start_run(input vec_t v);
    exp_t e;
    load_vec(v);
    ld_cyc.delete();
    req_max = 0;
    e.final_tap = v.exp_final;
    e.fail      = v.exp_fail;
    sb.push_back(e);
    pulse_start();
  endtask

  task automatic wait_done(input string name);
    int   n;
    exp_t e;
    n = 0;
    while (bus.done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) e = sb.pop_front();
    if (bus.done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: done=%b expected 1", name, bus.done);
    end else begin
      check({name, " final_tap"}, 64'(bus.final_tap), 64'(e.final_tap));
      check({name, " fail"}, 64'(bus.fail), 64'(e.fail));
      check({name, " busy"}, 64'(bus.busy), 64'd0);
    end
  endtask

  task automatic next_load(output logic [4:0] tap, output bit ok);
    int n;
    n = 0;
    ok = 0;
    tap = 5'd0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ld !== '1 && n < 2000);
    if (bus.ld === '1) begin
      ok = 1;
      tap = bus.cntvaluein[4:0];
    end
  endtask

  task automatic find_load(input logic [4:0] want, input string name);
    logic [4:0] tap;
    bit         ok;
    int         k;
    k = 0;
    do begin
      next_load(tap, ok);
      k++;
    end while (ok && tap != want && k < 40);
    if (!ok || tap != want) begin
      checks++;
      errors++;
      $display("FAIL %s: load of tap %0d not seen (last %0d)", name, want, tap);
    end
  endtask

  initial begin : main
    logic [4:0] tap;
    bit         ok;

    bus.start = 1'b0;
    bus.idelayctrl_rdy = 1'b1;
    mask = '0;
    stuck = '0;
    ack_len = 1;
    noise = 0;

    vecs[0] = '{mask: {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h000FFC00}, stuck: 4'b0000,
                ack_len: 1, noise: 0, exp_final: {5'd16, 5'd16, 5'd16, 5'd15}, exp_fail: 4'b0000};
    vecs[1] = '{mask: {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00F0003C, 32'hFFFFFFFF}, stuck: 4'b0000,
                ack_len: 1, noise: 1, exp_final: {5'd16, 5'd16, 5'd4, 5'd16}, exp_fail: 4'b0000};
    vecs[2] = '{mask: {32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF}, stuck: 4'b0000,
                ack_len: 1, noise: 0, exp_final: {5'd16, 5'd0, 5'd16, 5'd16}, exp_fail: 4'b0100};
    vecs[3] = '{mask: {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, stuck: 4'b1000,
                ack_len: 5, noise: 0, exp_final: {5'd16, 5'd16, 5'd16, 5'd16}, exp_fail: 4'b1000};
    vecs[4] = '{mask: {32'h55555555, 32'h7FFFFFFF, 32'h00000001, 32'h80000000}, stuck: 4'b0000,
                ack_len: 2, noise: 0, exp_final: {5'd0, 5'd15, 5'd0, 5'd31}, exp_fail: 4'b0000};
    vecs[5] = '{mask: {32'hFFFFFFFF, 32'h00000000, 32'h7FFFFFFE, 32'h00000F38}, stuck: 4'b0000,
                ack_len: 1, noise: 1, exp_final: {5'd16, 5'd0, 5'd16, 5'd10}, exp_fail: 4'b0100};

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst ld", 64'(bus.ld), 64'd0);
    check("rst cntvaluein", 64'(bus.cntvaluein), 64'd0);
    check("rst sample_req", 64'(bus.sample_req), 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst fail", 64'(bus.fail), 64'd0);
    check("rst final_tap", 64'(bus.final_tap), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle busy", 64'(bus.busy), 64'd0);

    for (int k = 0; k < 6; k++) begin
      start_run(vecs[k]);
      check($sformatf("vec%0d busy", k), 64'(bus.busy), 64'd1);
      check($sformatf("vec%0d done low", k), 64'(bus.done), 64'd0);
      wait_done($sformatf("vec%0d", k));
      check($sformatf("vec%0d req_len", k), 64'(req_max), 64'(vecs[k].ack_len));
      if (ld_cyc.size() >= 2)
        check($sformatf("vec%0d tap_latency", k), 64'(ld_cyc[1] - ld_cyc[0]),
              64'(2 + SETTLE + vecs[k].ack_len));
      else
        check($sformatf("vec%0d tap_latency", k), 64'(ld_cyc.size()), 64'd2);
    end

    // IDELAYCTRL ready lost for three cycles while loading tap 12.
    start_run(vecs[0]);
    find_load(5'd12, "rdy_drop");
    bus.idelayctrl_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rdy_drop sample_req", 64'(bus.sample_req), 64'd0);
      check("rdy_drop ld", 64'(bus.ld), 64'd0);
      check("rdy_drop busy", 64'(bus.busy), 64'd1);
    end
    bus.idelayctrl_rdy = 1'b1;
    next_load(tap, ok);
    check("rdy_drop restart tap", 64'({ok, tap}), 64'({1'b1, 5'd0}));
    wait_done("rdy_drop");

    // start while busy must not restart the sweep.
    start_run(vecs[2]);
    find_load(5'd5, "start_busy");
    pulse_start();
    next_load(tap, ok);
    check("start_busy next tap", 64'({ok, tap}), 64'({1'b1, 5'd6}));
    wait_done("start_busy");

    // Reset mid-sweep aborts; no activity until a new start.
    load_vec(vecs[0]);
    pulse_start();
    find_load(5'd3, "rst_abort");
    reset_n = 1'b0;
    #1;
    check("rst_abort busy", 64'(bus.busy), 64'd0);
    check("rst_abort ld", 64'(bus.ld), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_abort stays idle", 64'(bus.busy), 64'd0);
    check("rst_abort done", 64'(bus.done), 64'd0);
    check("rst_abort fail", 64'(bus.fail), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
